// File: rtl/seg_msg_pkg.sv
// Shared definitions for the seg display message sequencer: message ids,
// nibble codes, FSM state type, pattern lookup and leading-zero blanking.
package seg_msg_pkg;

  localparam int MSG_ID_W = 3;

  localparam logic [MSG_ID_W-1:0] MSG_GOOD  = 3'd0;
  localparam logic [MSG_ID_W-1:0] MSG_GOGO  = 3'd1;
  localparam logic [MSG_ID_W-1:0] MSG_LOSE  = 3'd2;
  localparam logic [MSG_ID_W-1:0] MSG_UP    = 3'd3;
  localparam logic [MSG_ID_W-1:0] MSG_DN    = 3'd4;
  localparam logic [MSG_ID_W-1:0] MSG_BLANK = 3'd5;

  localparam logic [3:0]  NIB_BLANK = 4'hF;
  localparam logic [15:0] SEG_BLANK = 16'hFFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  // Nibble codes for each canned word; reserved ids render blank.
  function automatic logic [15:0] msg_pattern(input logic [MSG_ID_W-1:0] id);
    logic [15:0] pat;
    case (id)
      MSG_GOOD: pat = 16'h900D;
      MSG_GOGO: pat = 16'h9090;
      MSG_LOSE: pat = 16'hC05E;
      MSG_UP:   pat = 16'hFFDE;
      MSG_DN:   pat = 16'hFFDA;
      default:  pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // Replace leading zero nibbles (MSB side) with blanks; the last digit
  // always stays visible so zero still reads as "0".
  function automatic logic [15:0] blank_leading(input logic [15:0] v);
    logic [15:0] r;
    logic        lead;
    r    = v;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (v[i*4 +: 4] == 4'h0)) r[i*4 +: 4] = NIB_BLANK;
      else                               lead = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_msg_sequencer_if.sv
// Message request channel between game logic (master) and the sequencer (slave).
interface seg_msg_sequencer_if;
  import seg_msg_pkg::*;

  logic                msg_valid;
  logic [MSG_ID_W-1:0] msg_id;
  logic                msg_ready;
  logic                msg_clear;

  modport master (output msg_valid, output msg_id, output msg_clear, input msg_ready);
  modport slave  (input msg_valid, input msg_id, input msg_clear, output msg_ready);
endinterface

// File: rtl/seg_tick_gen.sv
// Timing tick generator: one-cycle tick every TICK_DIV clocks. clr restarts
// the count so the first tick lands TICK_DIV cycles after the clr cycle.
module seg_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] cnt;

  assign tick = (cnt == TW'(TICK_DIV - 1));

  // Free-running divider, restarted by clr.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + TW'(1);
  end

endmodule

// File: rtl/seg_msg_sequencer.sv
// Builds the 4-nibble seg_data word: blanked live value when idle, canned
// words for HOLD_TICKS ticks on request, with a 1-deep pending slot.
// Optional build macro SEG_MSG_BLINK_EN: message blinks every BLINK_TICKS ticks.
module seg_msg_sequencer
  import seg_msg_pkg::*;
#(
  parameter int TICK_DIV    = 100000,
  parameter int HOLD_TICKS  = 1500,
  parameter int BLINK_TICKS = 250
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         value,
  seg_msg_sequencer_if.slave  msg,
  output logic [15:0]         seg_data,
  output logic                busy,
  output logic [MSG_ID_W-1:0] cur_msg
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  state_t              state_q, state_d;
  logic                pend_valid;
  logic [MSG_ID_W-1:0] pend_id;
  logic [HW-1:0]       hold_cnt;
  logic                tick;
  logic                accept, hold_expire, launch_ok, launch;
  logic [MSG_ID_W-1:0] launch_id;
  logic [15:0]         seg_data_d;
  logic                blink_off_d;

  assign msg.msg_ready = !pend_valid;
  assign busy          = (state_q == ST_SHOW);

  assign accept      = msg.msg_valid && !pend_valid && !msg.msg_clear;
  assign hold_expire = (state_q == ST_SHOW) && tick && (hold_cnt == HW'(HOLD_TICKS - 1));
  assign launch_ok   = (state_q == ST_IDLE) || hold_expire;
  assign launch      = !msg.msg_clear && launch_ok && (pend_valid || accept);
  assign launch_id   = pend_valid ? pend_id : msg.msg_id;

  seg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (launch || msg.msg_clear),
    .tick  (tick)
  );

`ifdef SEG_MSG_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_off;
  logic          blink_wrap;

  assign blink_wrap  = (blink_cnt == BW'(BLINK_TICKS - 1));
  assign blink_off_d = blink_off ^ ((state_q == ST_SHOW) && tick && blink_wrap);

  // Blink phase: restarts visible on every launch, toggles each BLINK_TICKS ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (msg.msg_clear || launch) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if ((state_q == ST_SHOW) && tick) begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
      blink_off <= blink_off_d;
    end
  end
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = (BLINK_TICKS > 0);
  assign blink_off_d      = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: clear wins, then launch, then plain expiry.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (msg.msg_clear)    state_d = ST_IDLE;
    else if (launch)      state_d = ST_SHOW;
    else if (hold_expire) state_d = ST_IDLE;
  end

  // FSM output: next display word for the registered seg_data.
  always_comb begin
    seg_data_d = blank_leading(value);
    if (launch)                    seg_data_d = msg_pattern(launch_id);
    else if (state_d == ST_SHOW)   seg_data_d = blink_off_d ? SEG_BLANK : msg_pattern(cur_msg);
  end

  // Output register, current id, hold counter and pending slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_data   <= SEG_BLANK;
      cur_msg    <= '0;
      hold_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_id    <= '0;
    end else begin
      seg_data <= seg_data_d;
      if (msg.msg_clear) begin
        hold_cnt   <= '0;
        pend_valid <= 1'b0;
      end else begin
        if (launch) begin
          cur_msg  <= launch_id;
          hold_cnt <= '0;
        end else if (hold_expire) begin
          hold_cnt <= '0;
        end else if ((state_q == ST_SHOW) && tick) begin
          hold_cnt <= hold_cnt + HW'(1);
        end
        if (launch && pend_valid) begin
          pend_valid <= 1'b0;
        end else if (accept && !launch) begin
          pend_valid <= 1'b1;
          pend_id    <= msg.msg_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Self-checking bench for seg_msg_sequencer with a cycle-level reference
// model built from display rules (message age in cycles, 1-entry queue).
module tb_seg_msg_sequencer;

  localparam int TD = 4;
  localparam int HT = 3;
  localparam int BT = 1;
  localparam int SHOW_LEN = HT * TD;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [15:0] seg_data;
  logic        busy;
  logic [2:0]  cur_msg;

  seg_msg_sequencer_if bus();

  seg_msg_sequencer #(.TICK_DIV(TD), .HOLD_TICKS(HT), .BLINK_TICKS(BT)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .msg      (bus),
    .seg_data (seg_data),
    .busy     (busy),
    .cur_msg  (cur_msg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit          m_show;
  logic [2:0]  m_id;
  int          m_age;
  bit          m_pend_v;
  logic [2:0]  m_pend_id;
  logic [15:0] m_seg;

  function automatic logic [15:0] ref_pattern(input logic [2:0] id);
    case (id)
      3'd0:    return 16'h900D;
      3'd1:    return 16'h9090;
      3'd2:    return 16'hC05E;
      3'd3:    return 16'hFFDE;
      3'd4:    return 16'hFFDA;
      default: return 16'hFFFF;
    endcase
  endfunction

  function automatic logic [15:0] ref_blank(input logic [15:0] v);
    int top = 0;
    logic [15:0] r = v;
    for (int i = 0; i < 4; i++) if (v[i*4 +: 4] != 4'h0) top = i;
    for (int i = 0; i < 4; i++) if (i > top) r[i*4 +: 4] = 4'hF;
    return r;
  endfunction

  function automatic logic [15:0] ref_visible(input logic [2:0] id, input int age);
`ifdef SEG_MSG_BLINK_EN
    if ((((age - 1) / (BT * TD)) % 2) == 1) return 16'hFFFF;
`endif
    return ref_pattern(id);
  endfunction

  task automatic model_reset();
    m_show = 0; m_id = 3'd0; m_age = 0; m_pend_v = 0; m_pend_id = 3'd0; m_seg = 16'hFFFF;
  endtask

  // Advance model by one clock using the inputs currently driven, then
  // advance the DUT to the next falling edge.
  task automatic step();
    bit rdy, acc, expiring;
    rdy = !m_pend_v;
    if (bus.msg_clear) begin
      m_show = 0; m_pend_v = 0; m_seg = ref_blank(value);
    end else begin
      acc      = bus.msg_valid && rdy;
      expiring = m_show && (m_age == SHOW_LEN);
      if ((!m_show || expiring) && (m_pend_v || acc)) begin
        if (m_pend_v) begin m_id = m_pend_id; m_pend_v = 0; end
        else begin m_id = bus.msg_id; acc = 0; end
        m_show = 1; m_age = 1; m_seg = ref_visible(m_id, 1);
      end else if (expiring || !m_show) begin
        m_show = 0; m_seg = ref_blank(value);
      end else begin
        m_age++; m_seg = ref_visible(m_id, m_age);
      end
      if (acc) begin m_pend_v = 1; m_pend_id = bus.msg_id; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.msg_valid = 0; bus.msg_id = 3'd0; bus.msg_clear = 0;
  endtask

  task automatic launch_msg(input logic [2:0] id);
    bus.msg_valid = 1; bus.msg_id = id;
    step();
    bus.msg_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; value = 16'h0042; drive_idle(); model_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({seg_data, busy, cur_msg, bus.msg_ready} !== {16'hFFFF, 1'b0, 3'd0, 1'b1}) begin
      bad++; $display("FAIL reset_state: got seg=%h busy=%b cur=%0d rdy=%b want seg=ffff busy=0 cur=0 rdy=1",
                      seg_data, busy, cur_msg, bus.msg_ready);
    end
    reset = 0;
    step();
    total++;
    if (seg_data !== 16'hFF42) begin bad++; $display("FAIL blank_0042: got %h want ff42", seg_data); end
    value = 16'h0000; step();
    total++;
    if ({seg_data, busy, bus.msg_ready} !== {16'hFFF0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL blank_0000: got seg=%h busy=%b rdy=%b want fff0 0 1", seg_data, busy, bus.msg_ready);
    end
    value = 16'h1005; step();
    total++;
    if (seg_data !== 16'h1005) begin bad++; $display("FAIL blank_1005: got %h want 1005", seg_data); end
  endtask

  task automatic test_good();
    int n900d = 0;
    int want_n;
    value = 16'h0300;
    launch_msg(3'd0);
    total++;
    if ({seg_data, busy, cur_msg} !== {16'h900D, 1'b1, 3'd0}) begin
      bad++; $display("FAIL good_launch: got seg=%h busy=%b cur=%0d want 900d 1 0", seg_data, busy, cur_msg);
    end
    if (seg_data == 16'h900D) n900d++;
    for (int i = 0; i < SHOW_LEN + 3; i++) begin
      step();
      total++;
      if ({seg_data, busy, cur_msg, bus.msg_ready} !== {m_seg, m_show, m_id, !m_pend_v}) begin
        bad++; $display("FAIL good_cycle%0d: got seg=%h busy=%b cur=%0d rdy=%b want %h %b %0d %b",
                        i, seg_data, busy, cur_msg, bus.msg_ready, m_seg, m_show, m_id, !m_pend_v);
      end
      if (seg_data == 16'h900D) n900d++;
    end
`ifdef SEG_MSG_BLINK_EN
    want_n = SHOW_LEN - BT * TD;
`else
    want_n = SHOW_LEN;
`endif
    total++;
    if (n900d !== want_n) begin bad++; $display("FAIL good_len: got %0d cycles want %0d", n900d, want_n); end
    total++;
    if (seg_data !== 16'hF300) begin bad++; $display("FAIL good_revert: got %h want f300", seg_data); end
  endtask

  task automatic test_queue();
    logic [15:0] prev;
    bit accepted = 0;
    bit saw_lose = 0;
    value = 16'h0007;
    launch_msg(3'd0);
    step(); step();
    launch_msg(3'd2);
    total++;
    if (bus.msg_ready !== 1'b0) begin bad++; $display("FAIL queue_ready: got %b want 0", bus.msg_ready); end
    bus.msg_valid = 1; bus.msg_id = 3'd1;
    prev = seg_data;
    for (int i = 0; i < 40 && !accepted; i++) begin
      accepted = !m_pend_v;
      step();
      if (accepted) bus.msg_valid = 0;
      total++;
      if ({seg_data, busy, cur_msg, bus.msg_ready} !== {m_seg, m_show, m_id, !m_pend_v}) begin
        bad++; $display("FAIL queue_cycle%0d: got seg=%h busy=%b cur=%0d rdy=%b want %h %b %0d %b",
                        i, seg_data, busy, cur_msg, bus.msg_ready, m_seg, m_show, m_id, !m_pend_v);
      end
      if (!saw_lose && seg_data == 16'hC05E) begin
        saw_lose = 1;
        total++;
        if (prev !== 16'h900D) begin bad++; $display("FAIL queue_gap: before c05e got %h want 900d", prev); end
      end
      prev = seg_data;
    end
    total++;
    if (!accepted) begin bad++; $display("FAIL queue_stall_timeout: third request never accepted"); end
    bus.msg_valid = 0;
    for (int i = 0; i < 2 * SHOW_LEN + 4; i++) begin
      step();
      total++;
      if ({seg_data, busy, cur_msg, bus.msg_ready} !== {m_seg, m_show, m_id, !m_pend_v}) begin
        bad++; $display("FAIL queue_drain%0d: got seg=%h busy=%b cur=%0d want %h %b %0d",
                        i, seg_data, busy, cur_msg, m_seg, m_show, m_id);
      end
    end
  endtask

  task automatic test_seamless();
    int guard = 0;
    value = 16'h0000;
    launch_msg(3'd0);
    while (!(m_show && m_age == SHOW_LEN) && guard < 30) begin step(); guard++; end
    total++;
    if (bus.msg_ready !== 1'b1) begin bad++; $display("FAIL seamless_ready: got %b want 1", bus.msg_ready); end
    bus.msg_valid = 1; bus.msg_id = 3'd3;
    step();
    bus.msg_valid = 0;
    total++;
    if ({seg_data, busy, cur_msg, bus.msg_ready} !== {16'hFFDE, 1'b1, 3'd3, 1'b1}) begin
      bad++; $display("FAIL seamless_launch: got seg=%h busy=%b cur=%0d rdy=%b want ffde 1 3 1",
                      seg_data, busy, cur_msg, bus.msg_ready);
    end
    repeat (SHOW_LEN + 2) step();
    total++;
    if ({seg_data, busy} !== {16'hFFF0, 1'b0}) begin
      bad++; $display("FAIL seamless_end: got seg=%h busy=%b want fff0 0", seg_data, busy);
    end
  endtask

  task automatic test_clear_and_reset();
    value = 16'h0250;
    launch_msg(3'd0);
    repeat (3) step();
    launch_msg(3'd2);
    bus.msg_clear = 1; bus.msg_valid = 1; bus.msg_id = 3'd4;
    step();
    bus.msg_clear = 0; bus.msg_valid = 0;
    total++;
    if ({seg_data, busy, bus.msg_ready} !== {16'hF250, 1'b0, 1'b1}) begin
      bad++; $display("FAIL clear: got seg=%h busy=%b rdy=%b want f250 0 1", seg_data, busy, bus.msg_ready);
    end
    for (int i = 0; i < SHOW_LEN + 8; i++) begin
      step();
      total++;
      if (seg_data === 16'hC05E || seg_data === 16'hFFDA || seg_data !== m_seg || busy !== m_show) begin
        bad++; $display("FAIL clear_after%0d: got seg=%h busy=%b want %h %b", i, seg_data, busy, m_seg, m_show);
      end
    end
    launch_msg(3'd2);
    repeat (4) step();
    #2 reset = 1;
    #1;
    total++;
    if ({seg_data, busy, cur_msg, bus.msg_ready} !== {16'hFFFF, 1'b0, 3'd0, 1'b1}) begin
      bad++; $display("FAIL reset_mid_show: got seg=%h busy=%b cur=%0d rdy=%b want ffff 0 0 1",
                      seg_data, busy, cur_msg, bus.msg_ready);
    end
    model_reset();
    @(negedge clk);
    reset = 0;
    step();
    total++;
    if ({seg_data, busy} !== {16'hF250, 1'b0}) begin
      bad++; $display("FAIL after_reset: got seg=%h busy=%b want f250 0", seg_data, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 4; k++)
        value[k*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      bus.msg_valid = ($urandom_range(0, 99) < 15);
      bus.msg_id    = 3'($urandom_range(0, 7));
      bus.msg_clear = ($urandom_range(0, 99) < 2);
      step();
      total++;
      if ({seg_data, busy, cur_msg, bus.msg_ready} !== {m_seg, m_show, m_id, !m_pend_v}) begin
        bad++; $display("FAIL random%0d: got seg=%h busy=%b cur=%0d rdy=%b want %h %b %0d %b",
                        i, seg_data, busy, cur_msg, bus.msg_ready, m_seg, m_show, m_id, !m_pend_v);
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_good();
    test_queue();
    test_seamless();
    test_clear_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
